// File: rtl/z3_isa_cycle.sv
// rtl/z3_isa_cycle.sv - Zorro III slave cycle controller feeding the ISA strobe generator
// Synchronises nFCS/nDS, decodes the board window and sequences en, nSLAVEN and nDTACK.
module z3_isa_cycle #(
    parameter int BASE_BITS     = 16,
    parameter int STROBE_CYCLES = 8,
    parameter int STROBE_LAT    = 7,
    parameter int CNT_W         = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 nFCS,
    input  logic [3:0]           nDS,
    input  logic                 READ,
    input  logic [BASE_BITS-1:0] addr,
    input  logic [BASE_BITS-1:0] base,
    input  logic                 configured,
    output logic                 nSLAVEN,
    output logic                 en,
    output logic                 read,
    output logic                 nDTACK,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_STROBE,
        S_RECOVER,
        S_ACK,
        S_END
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             aborted_q;
    logic             fcs_meta_q, fcs_s_q, fcs_prev_q;
    logic             ds_meta_q, ds_s_q;
    logic             nslaven_q, en_q, read_q, ndtack_q, busy_q;

    logic fcs_rise;
    logic hit;

    // Edge detection keeps a strobe still low from the previous cycle from retriggering.
    assign fcs_rise = fcs_s_q & ~fcs_prev_q;
    assign hit      = configured && (addr == base);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            aborted_q  <= 1'b0;
            fcs_meta_q <= 1'b0;
            fcs_s_q    <= 1'b0;
            fcs_prev_q <= 1'b0;
            ds_meta_q  <= 1'b0;
            ds_s_q     <= 1'b0;
            nslaven_q  <= 1'b1;
            en_q       <= 1'b0;
            read_q     <= 1'b1;
            ndtack_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            fcs_meta_q <= ~nFCS;
            fcs_s_q    <= fcs_meta_q;
            fcs_prev_q <= fcs_s_q;
            ds_meta_q  <= ~&nDS;
            ds_s_q     <= ds_meta_q;

            case (state_q)
                S_IDLE: begin
                    if (fcs_rise && hit) begin
                        read_q    <= READ;
                        nslaven_q <= 1'b0;
                        busy_q    <= 1'b1;
                        aborted_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!fcs_s_q) begin
                        nslaven_q <= 1'b1;
                        read_q    <= 1'b1;
                        ndtack_q  <= 1'b1;
                        state_q   <= S_END;
                    end else if (ds_s_q) begin
                        en_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (!fcs_s_q || cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                        aborted_q <= aborted_q | ~fcs_s_q;
                        en_q      <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_RECOVER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    // The downstream strobe is already in flight, so an abort still waits it out.
                    if (cnt_q == CNT_W'(STROBE_LAT - 1)) begin
                        cnt_q <= '0;
                        if (aborted_q || !fcs_s_q) begin
                            nslaven_q <= 1'b1;
                            read_q    <= 1'b1;
                            ndtack_q  <= 1'b1;
                            state_q   <= S_END;
                        end else begin
                            ndtack_q <= 1'b0;
                            state_q  <= S_ACK;
                        end
                    end else begin
                        aborted_q <= aborted_q | ~fcs_s_q;
                        cnt_q     <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (!fcs_s_q) begin
                        nslaven_q <= 1'b1;
                        read_q    <= 1'b1;
                        ndtack_q  <= 1'b1;
                        state_q   <= S_END;
                    end
                end
                S_END: begin
                    busy_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    nslaven_q <= 1'b1;
                    en_q      <= 1'b0;
                    read_q    <= 1'b1;
                    ndtack_q  <= 1'b1;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign nSLAVEN = nslaven_q;
    assign en      = en_q;
    assign read    = read_q;
    assign nDTACK  = ndtack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_z3_isa_cycle.sv
// tb/tb_z3_isa_cycle.sv - directed self-checking bench for z3_isa_cycle
module tb_z3_isa_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        nFCS;
    logic [3:0]  nDS;
    logic        READ;
    logic [15:0] addr;
    logic [15:0] base;
    logic        configured;
    logic        nSLAVEN, en, read, nDTACK, busy;

    int checks   = 0;
    int failures = 0;

    int m_sl, m_en_rise, m_en_fall, m_dtack, m_rel, m_sl_hi, m_idle, m_en_cnt;
    bit m_read_bad, m_overlap;

    z3_isa_cycle dut (
        .clk        (clk),
        .reset      (reset),
        .nFCS       (nFCS),
        .nDS        (nDS),
        .READ       (READ),
        .addr       (addr),
        .base       (base),
        .configured (configured),
        .nSLAVEN    (nSLAVEN),
        .en         (en),
        .read       (read),
        .nDTACK     (nDTACK),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Drives one bus cycle from the negedge and records event indices (posedges since nFCS fell).
    task automatic run_cycle(input logic rd, input int abort_at);
        bit released = 0;
        bit seen_busy = 0;
        m_sl = -1; m_en_rise = -1; m_en_fall = -1; m_dtack = -1;
        m_rel = -1; m_sl_hi = -1; m_idle = -1; m_en_cnt = 0;
        m_read_bad = 0; m_overlap = 0;
        READ = rd; nFCS = 1'b0; nDS = 4'h0;
        for (int idx = 1; idx <= 80; idx++) begin
            @(negedge clk);
            if (m_sl < 0 && nSLAVEN == 1'b0) m_sl = idx;
            if (en) begin
                if (m_en_rise < 0) m_en_rise = idx;
                m_en_cnt++;
                if (!nDTACK) m_overlap = 1;
            end else if (m_en_rise >= 0 && m_en_fall < 0) begin
                m_en_fall = idx;
            end
            if (nSLAVEN == 1'b0 && read !== rd) m_read_bad = 1;
            if (m_dtack < 0 && nDTACK == 1'b0) m_dtack = idx;
            if (m_sl >= 0 && m_sl_hi < 0 && nSLAVEN == 1'b1) m_sl_hi = idx;
            if (busy) seen_busy = 1;
            else if (seen_busy && m_idle < 0) m_idle = idx;
            if (!released && ((abort_at > 0 && en && m_en_cnt == abort_at) ||
                              (abort_at == 0 && nDTACK == 1'b0))) begin
                nFCS = 1'b1; nDS = 4'hF; released = 1; m_rel = idx;
            end
            if (m_idle >= 0) break;
        end
        nFCS = 1'b1; nDS = 4'hF;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (nSLAVEN !== 1'b1) begin failures++; $display("FAIL reset_nslaven got=%b exp=1", nSLAVEN); end
        checks++; if (en !== 1'b0)      begin failures++; $display("FAIL reset_en got=%b exp=0", en); end
        checks++; if (read !== 1'b1)    begin failures++; $display("FAIL reset_read got=%b exp=1", read); end
        checks++; if (nDTACK !== 1'b1)  begin failures++; $display("FAIL reset_ndtack got=%b exp=1", nDTACK); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_hit;
        run_cycle(1'b1, 0);
        checks++; if (m_idle < 0)       begin failures++; $display("FAIL read_timeout got=%0d exp=done", m_idle); end
        checks++; if (m_sl != 3)        begin failures++; $display("FAIL read_nslaven_lat got=%0d exp=3", m_sl); end
        checks++; if (m_en_rise != 4)   begin failures++; $display("FAIL read_en_rise got=%0d exp=4", m_en_rise); end
        checks++; if (m_en_cnt != 8)    begin failures++; $display("FAIL read_en_width got=%0d exp=8", m_en_cnt); end
        checks++; if (m_read_bad)       begin failures++; $display("FAIL read_level got=bad exp=stable_1"); end
        checks++; if (m_dtack - m_en_fall != 7) begin failures++; $display("FAIL read_dtack_gap got=%0d exp=7", m_dtack - m_en_fall); end
        checks++; if (m_overlap)        begin failures++; $display("FAIL read_dtack_overlap got=1 exp=0"); end
        checks++; if (m_sl_hi - m_rel < 1 || m_sl_hi - m_rel > 4) begin failures++; $display("FAIL read_release_lat got=%0d exp<=4", m_sl_hi - m_rel); end
        checks++; if (m_idle != m_sl_hi + 1) begin failures++; $display("FAIL read_end_len got=%0d exp=%0d", m_idle, m_sl_hi + 1); end
        checks++; if (nDTACK !== 1'b1)  begin failures++; $display("FAIL read_ndtack_after got=%b exp=1", nDTACK); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_hit;
        run_cycle(1'b0, 0);
        checks++; if (m_en_cnt != 8)    begin failures++; $display("FAIL write_en_width got=%0d exp=8", m_en_cnt); end
        checks++; if (m_read_bad)       begin failures++; $display("FAIL write_level got=bad exp=stable_0"); end
        checks++; if (m_dtack - m_en_fall != 7) begin failures++; $display("FAIL write_dtack_gap got=%0d exp=7", m_dtack - m_en_fall); end
        checks++; if (read !== 1'b1)    begin failures++; $display("FAIL write_read_after got=%b exp=1", read); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_miss(input logic [15:0] a, input logic cfg);
        bit bad = 0;
        addr = a; configured = cfg;
        nFCS = 1'b0; nDS = 4'h0; READ = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (nSLAVEN !== 1'b1 || en !== 1'b0 || nDTACK !== 1'b1 || busy !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL miss_idle addr=%h cfg=%b got=responded exp=idle", a, cfg); end
        nFCS = 1'b1; nDS = 4'hF;
        addr = 16'h4000; configured = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_abort;
        run_cycle(1'b1, 3);
        checks++; if (m_idle < 0)       begin failures++; $display("FAIL abort_timeout got=%0d exp=done", m_idle); end
        checks++; if (m_en_cnt != 5)    begin failures++; $display("FAIL abort_en_width got=%0d exp=5", m_en_cnt); end
        checks++; if (m_dtack != -1)    begin failures++; $display("FAIL abort_ndtack got=%0d exp=-1", m_dtack); end
        checks++; if (m_sl_hi != m_en_fall + 7) begin failures++; $display("FAIL abort_recover got=%0d exp=%0d", m_sl_hi, m_en_fall + 7); end
        checks++; if (m_idle != m_en_fall + 8)  begin failures++; $display("FAIL abort_idle got=%0d exp=%0d", m_idle, m_en_fall + 8); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_strobe;
        READ = 1'b0; nFCS = 1'b0; nDS = 4'h0;
        repeat (6) @(negedge clk);
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_en got=%b exp=1", en); end
        reset = 1'b1; nFCS = 1'b1; nDS = 4'hF;
        @(negedge clk);
        checks++; if ({nSLAVEN, en, read, nDTACK, busy} !== 5'b10110) begin
            failures++; $display("FAIL rst_mid_outputs got=%b exp=10110", {nSLAVEN, en, read, nDTACK, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_cycle(1'b0, 0);
        checks++; if (m_en_cnt != 8)  begin failures++; $display("FAIL rst_mid_next_en got=%0d exp=8", m_en_cnt); end
        checks++; if (m_read_bad)     begin failures++; $display("FAIL rst_mid_next_read got=bad exp=stable_0"); end
        checks++; if (m_dtack - m_en_fall != 7) begin failures++; $display("FAIL rst_mid_next_dtack got=%0d exp=7", m_dtack - m_en_fall); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit bad = 0;
        int en_cnt = 0;
        READ = 1'b1; nFCS = 1'b0; nDS = 4'h0;
        repeat (6) @(negedge clk);
        nFCS = 1'b1;
        repeat (2) @(negedge clk);
        nFCS = 1'b0;
        // nFCS stays low through RECOVER/END, so IDLE must not see a new rise.
        repeat (12) @(negedge clk);
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || nSLAVEN !== 1'b1) bad = 1;
            if (en) en_cnt++;
        end
        checks++; if (bad)         begin failures++; $display("FAIL b2b_no_retrigger got=busy exp=idle"); end
        checks++; if (en_cnt != 0) begin failures++; $display("FAIL b2b_stray_en got=%0d exp=0", en_cnt); end
        nFCS = 1'b1; nDS = 4'hF;
        repeat (3) @(negedge clk);
        run_cycle(1'b1, 0);
        checks++; if (m_en_cnt != 8) begin failures++; $display("FAIL b2b_first_en got=%0d exp=8", m_en_cnt); end
        run_cycle(1'b0, 0);
        checks++; if (m_en_cnt != 8) begin failures++; $display("FAIL b2b_second_en got=%0d exp=8", m_en_cnt); end
        checks++; if (m_read_bad)    begin failures++; $display("FAIL b2b_second_read got=bad exp=stable_0"); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; nFCS = 1'b1; nDS = 4'hF; READ = 1'b1;
        addr = 16'h4000; base = 16'h4000; configured = 1'b1;
        @(negedge clk);
        test_reset;
        test_read_hit;
        test_write_hit;
        test_miss(16'h4001, 1'b1);
        test_miss(16'h4000, 1'b0);
        test_abort;
        test_reset_mid_strobe;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
